// File: rtl/uart_pkg.sv
// Shared types and helpers for the uart_tx_pin transmitter slice.
// The optional UART_TX_PARITY_EN build adds the PARITY state to the frame.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } uart_tx_state_t;

    localparam int UART_DATA_W = 8;

    // Clock cycles per bit; any fractional part of the ratio is truncated.
    function automatic int calc_div(input int clk_hz, input int baud);
        return clk_hz / baud;
    endfunction

endpackage

// File: rtl/uart_tx_pin_if.sv
// Byte handshake between a producer and the uart_tx_pin transmitter.
interface uart_tx_pin_if;
    import uart_pkg::*;

    logic [UART_DATA_W-1:0] tx_data;
    logic                   tx_valid;
    logic                   tx_ready;

    modport master (output tx_data, output tx_valid, input tx_ready);
    modport slave  (input tx_data, input tx_valid, output tx_ready);

endinterface

// File: rtl/uart_baud_gen.sv
// Bit-period counter: counts 0..DIV-1 and pulses tick on the last count.
// clear restarts the period so the first bit boundary lands exactly DIV cycles later.
module uart_baud_gen #(
    parameter int DIV = 694
) (
    input  logic clk,
    input  logic arst_n,
    input  logic clear,
    output logic tick
);

    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;

    logic [CW-1:0] baud_cnt;

    assign tick = (baud_cnt == CW'(DIV - 1));

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            baud_cnt <= '0;
        end else if (clear || tick) begin
            baud_cnt <= '0;
        end else begin
            baud_cnt <= baud_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/uart_tx_pin.sv
// Byte-wide UART transmitter (8N1/8N2) driving a registered TX pin.
// Define UART_TX_PARITY_EN to append an even-parity bit after the data bits.
module uart_tx_pin
    import uart_pkg::*;
#(
    parameter int CLK_HZ    = 80_000_000,
    parameter int BAUD      = 115_200,
    parameter int STOP_BITS = 1
) (
    input  logic            clk,
    input  logic            arst_n,
    uart_tx_pin_if.slave    tx,
    output logic            tx_busy,
    output logic            txd
);

    localparam int DIV = calc_div(CLK_HZ, BAUD);
    localparam logic STOP_LAST = 1'(STOP_BITS - 1);

    if (DIV < 2) begin : g_bad_div
        $error("uart_tx_pin: CLK_HZ/BAUD must be at least 2");
    end
    if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_bad_stop
        $error("uart_tx_pin: STOP_BITS must be 1 or 2");
    end

    uart_tx_state_t         state_q, state_d;
    logic                   txd_q, txd_d;
    logic [UART_DATA_W-1:0] shift_q;
    logic [2:0]             bit_cnt;
    logic                   stop_cnt;
    logic                   rst_done_q;
    logic                   tick;
    logic                   xfer;
`ifdef UART_TX_PARITY_EN
    logic                   parity_q;
`endif

    // Ready is held low through the first edge after reset release.
    assign tx.tx_ready = rst_done_q && (state_q == IDLE);
    assign xfer        = tx.tx_valid && tx.tx_ready;
    assign tx_busy     = (state_q != IDLE);
    assign txd         = txd_q;

    uart_baud_gen #(.DIV(DIV)) u_baud (
        .clk    (clk),
        .arst_n (arst_n),
        .clear  (xfer),
        .tick   (tick)
    );

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            state_q    <= IDLE;
            txd_q      <= 1'b1;
            rst_done_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            txd_q      <= txd_d;
            rst_done_q <= 1'b1;
        end
    end

    // txd_d is the line level for the state being entered, so the pin is a pure flop.
    always_comb begin
        state_d = state_q;
        txd_d   = txd_q;
        case (state_q)
            IDLE: begin
                txd_d = 1'b1;
                if (xfer) begin
                    state_d = START;
                    txd_d   = 1'b0;
                end
            end
            START: begin
                if (tick) begin
                    state_d = DATA;
                    txd_d   = shift_q[0];
                end
            end
            DATA: begin
                if (tick) begin
                    if (bit_cnt == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                        state_d = PARITY;
                        txd_d   = parity_q;
`else
                        state_d = STOP;
                        txd_d   = 1'b1;
`endif
                    end else begin
                        txd_d = shift_q[1];
                    end
                end
            end
            PARITY: begin
                if (tick) begin
                    state_d = STOP;
                    txd_d   = 1'b1;
                end
            end
            STOP: begin
                if (tick && stop_cnt == STOP_LAST) begin
                    state_d = IDLE;
                    txd_d   = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                txd_d   = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            shift_q  <= '0;
            bit_cnt  <= '0;
            stop_cnt <= 1'b0;
`ifdef UART_TX_PARITY_EN
            parity_q <= 1'b0;
`endif
        end else if (xfer) begin
            shift_q  <= tx.tx_data;
            bit_cnt  <= '0;
            stop_cnt <= 1'b0;
`ifdef UART_TX_PARITY_EN
            parity_q <= ^tx.tx_data;
`endif
        end else if (tick) begin
            if (state_q == DATA) begin
                shift_q <= shift_q >> 1;
                bit_cnt <= bit_cnt + 3'd1;
            end
            if (state_q == STOP) begin
                stop_cnt <= stop_cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_uart_tx_pin.sv
// Self-checking bench for uart_tx_pin: frames are compared cycle by cycle against a
// bit-list model of the UART frame (start, data LSB first, optional parity, stop).
`timescale 1ns/1ps
module tb_uart_tx_pin;

    localparam int CLK_HZ    = 1_000_000;
    localparam int BAUD      = 100_000;
    localparam int DIV       = 10;
    localparam int STOP_BITS = 1;
`ifdef UART_TX_PARITY_EN
    localparam int P = 1;
`else
    localparam int P = 0;
`endif
    localparam int FRAME_BITS = 1 + 8 + P + STOP_BITS;
    localparam int FLEN       = FRAME_BITS * DIV;

    logic clk = 1'b0;
    logic arst_n = 1'b0;
    logic tx_busy;
    logic txd;
    int   checks = 0;
    int   errors = 0;

    uart_tx_pin_if bus ();

    uart_tx_pin #(
        .CLK_HZ    (CLK_HZ),
        .BAUD      (BAUD),
        .STOP_BITS (STOP_BITS)
    ) dut (
        .clk     (clk),
        .arst_n  (arst_n),
        .tx      (bus),
        .tx_busy (tx_busy),
        .txd     (txd)
    );

    always #500 clk = ~clk;

    // Line level of bit slot idx in the frame carrying byte b.
    function automatic logic model_bit(input logic [7:0] b, input int idx);
        if (idx == 0) return 1'b0;
        if (idx <= 8) return b[idx-1];
        if (P == 1 && idx == 9) return ($countones(b) % 2) == 1;
        return 1'b1;
    endfunction

    task automatic send_byte(input logic [7:0] b, input bit hold_valid);
        bit ok;
        ok = 1'b0;
        bus.tx_data  = b;
        bus.tx_valid = 1'b1;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (bus.tx_ready === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
        checks++;
        if (!ok) begin
            errors++;
            $display("[TB] FAIL accept_timeout byte=%02h tx_ready got %b exp 1", b, bus.tx_ready);
        end
        @(posedge clk);
        #1;
        if (!hold_valid) bus.tx_valid = 1'b0;
    endtask

    // Called just after the transfer edge; ends at the negedge of the idle cycle after the frame.
    task automatic check_frame(input logic [7:0] b, input string tag);
        logic exp;
        for (int k = 0; k < FLEN; k++) begin
            @(negedge clk);
            exp = model_bit(b, k / DIV);
            checks += 3;
            if (txd !== exp) begin
                errors++;
                $display("[TB] FAIL %s txd cycle %0d got %b exp %b", tag, k, txd, exp);
            end
            if (tx_busy !== 1'b1) begin
                errors++;
                $display("[TB] FAIL %s tx_busy cycle %0d got %b exp 1", tag, k, tx_busy);
            end
            if (bus.tx_ready !== 1'b0) begin
                errors++;
                $display("[TB] FAIL %s tx_ready cycle %0d got %b exp 0", tag, k, bus.tx_ready);
            end
        end
        @(negedge clk);
        checks++;
        if ({txd, tx_busy, bus.tx_ready} !== 3'b101) begin
            errors++;
            $display("[TB] FAIL %s idle txd/busy/ready got %b%b%b exp 101", tag, txd, tx_busy, bus.tx_ready);
        end
    endtask

    task automatic test_reset();
        bus.tx_valid = 1'b0;
        bus.tx_data  = 8'h00;
        arst_n = 1'b0;
        #1200;
        checks++;
        if ({txd, tx_busy, bus.tx_ready} !== 3'b100) begin
            errors++;
            $display("[TB] FAIL reset_state txd/busy/ready got %b%b%b exp 100", txd, tx_busy, bus.tx_ready);
        end
        @(negedge clk);
        #100 arst_n = 1'b1;
        #1;
        checks++;
        if (bus.tx_ready !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_release_ready got %b exp 0", bus.tx_ready);
        end
        @(posedge clk);
        #1;
        checks++;
        if (bus.tx_ready !== 1'b1) begin
            errors++;
            $display("[TB] FAIL ready_after_release got %b exp 1", bus.tx_ready);
        end
    endtask

    task automatic test_single_a5();
        send_byte(8'hA5, 1'b0);
        check_frame(8'hA5, "a5");
    endtask

    task automatic test_back_to_back();
        send_byte(8'h00, 1'b1);
        bus.tx_data = 8'hFF;
        check_frame(8'h00, "b2b_00");
        @(posedge clk);
        #1 bus.tx_valid = 1'b0;
        check_frame(8'hFF, "b2b_ff");
    endtask

    task automatic test_data_change();
        send_byte(8'h5A, 1'b0);
        bus.tx_data = 8'hC3;
        check_frame(8'h5A, "data_change");
    endtask

    task automatic test_reset_mid_frame();
        logic exp;
        send_byte(8'h3C, 1'b0);
        for (int k = 0; k <= 55; k++) @(negedge clk);
        exp = model_bit(8'h3C, 5);
        checks++;
        if (txd !== exp) begin
            errors++;
            $display("[TB] FAIL midframe_pre txd got %b exp %b", txd, exp);
        end
        #100 arst_n = 1'b0;
        #1;
        checks++;
        if ({txd, tx_busy, bus.tx_ready} !== 3'b100) begin
            errors++;
            $display("[TB] FAIL midframe_reset txd/busy/ready got %b%b%b exp 100", txd, tx_busy, bus.tx_ready);
        end
        @(posedge clk);
        @(negedge clk);
        #100 arst_n = 1'b1;
        send_byte(8'h81, 1'b0);
        check_frame(8'h81, "after_reset_81");
    endtask

    task automatic test_parity();
        logic [7:0] bytes [2];
        logic       par_exp [2];
        int         len;
        logic       par;
        bytes[0] = 8'h07;
        bytes[1] = 8'h03;
`ifdef UART_TX_PARITY_EN
        par_exp[0] = 1'b1;
        par_exp[1] = 1'b0;
`else
        par_exp[0] = 1'b1;
        par_exp[1] = 1'b1;
`endif
        for (int n = 0; n < 2; n++) begin
            send_byte(bytes[n], 1'b0);
            len = 0;
            par = 1'bx;
            for (int i = 0; i < 300; i++) begin
                @(negedge clk);
                if (tx_busy !== 1'b1) break;
                if (i == 95) par = txd;
                len++;
            end
            checks += 2;
            if (len != ((P == 1) ? 110 : 100)) begin
                errors++;
                $display("[TB] FAIL frame_len byte=%02h got %0d exp %0d", bytes[n], len, (P == 1) ? 110 : 100);
            end
            if (par !== par_exp[n]) begin
                errors++;
                $display("[TB] FAIL slot9 byte=%02h txd got %b exp %b", bytes[n], par, par_exp[n]);
            end
        end
    endtask

    task automatic test_random();
        logic [7:0] b;
        int gap;
        for (int n = 0; n < 10; n++) begin
            b   = 8'($urandom);
            gap = $urandom_range(0, 5);
            repeat (gap) @(posedge clk);
            send_byte(b, 1'b0);
            check_frame(b, $sformatf("rand%0d_%02h", n, b));
        end
    endtask

    initial begin
        $display("[TB] uart_tx_pin bench, DIV=%0d, frame=%0d cycles", DIV, FLEN);
        test_reset();
        test_single_a5();
        test_back_to_back();
        test_data_change();
        test_reset_mid_frame();
        test_parity();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
